// File: rtl/lfsr_rand_gen.sv
// rtl/lfsr_rand_gen.sv - XNOR Fibonacci LFSR with bounded rejection-sampled output
// Optional: define LFSR_REJECT_CNT_EN to add the saturating reject_cnt output.
module lfsr_rand_gen #(
  parameter int WIDTH     = 8,
  parameter int MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] lfsr,
  output logic             wrap,
  output logic             busy,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] rnd
`ifdef LFSR_REJECT_CNT_EN
  ,
  output logic [15:0]      reject_cnt
`endif
);

  generate
    if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
      $error("lfsr_rand_gen: WIDTH must be in 3..16");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 255) begin : g_bad_tries
      $error("lfsr_rand_gen: MAX_TRIES must be in 1..255");
    end
  endgenerate

  // Maximal-length tap sets; bit n-1 set for tap n.
  function automatic logic [15:0] tap_mask(input int w);
    case (w)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  localparam logic [15:0]      TAPS     = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAP_BITS = TAPS[WIDTH-1:0];
  localparam logic [7:0]       TRY_LAST = 8'(MAX_TRIES - 1);

  typedef enum logic [0:0] {IDLE, SAMPLE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       tries_q, tries_d;
  logic [WIDTH-1:0] limit_reg, limit_d;
  logic [WIDTH-1:0] seed_reg;
  logic [WIDTH-1:0] rnd_d;
  logic             rnd_valid_d;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] lfsr_next;
  logic             advance;

  // XNOR feedback keeps all-ones as the unreachable lockup state.
  assign lfsr_next = {lfsr[WIDTH-2:0], ~^(lfsr & TAP_BITS)};
  assign advance   = (state_q == IDLE && ce) || (state_q == SAMPLE);
  assign busy      = (state_q == SAMPLE);
  assign cand      = lfsr & mask;

  // Smear limit bits downward: smallest 2^k-1 covering limit_reg.
  always_comb begin
    mask = limit_reg;
    for (int i = 1; i < WIDTH; i++) begin
      mask = mask | (limit_reg >> i);
    end
  end

  // LFSR state, seed shadow and period-wrap pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr     <= '0;
      seed_reg <= '0;
      wrap     <= 1'b0;
    end else if (seed_load) begin
      lfsr     <= (&seed) ? '0 : seed;
      seed_reg <= (&seed) ? '0 : seed;
      wrap     <= 1'b0;
    end else if (advance) begin
      lfsr     <= lfsr_next;
      wrap     <= (lfsr_next == seed_reg);
    end else begin
      wrap     <= 1'b0;
    end
  end

  // Sampling FSM next-state: accept in-range candidate or fall back after the last try.
  always_comb begin
    state_d     = state_q;
    tries_d     = tries_q;
    limit_d     = limit_reg;
    rnd_d       = rnd;
    rnd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          limit_d = limit;
          tries_d = 8'd0;
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (cand <= limit_reg) begin
          rnd_d       = cand;
          rnd_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (tries_q == TRY_LAST) begin
          rnd_d       = cand - limit_reg - WIDTH'(1);
          rnd_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          tries_d = tries_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sampling FSM registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tries_q   <= 8'd0;
      limit_reg <= '0;
      rnd       <= '0;
      rnd_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      tries_q   <= tries_d;
      limit_reg <= limit_d;
      rnd       <= rnd_d;
      rnd_valid <= rnd_valid_d;
    end
  end

`ifdef LFSR_REJECT_CNT_EN
  // Count rejected SAMPLE cycles (fallback cycle included), saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      reject_cnt <= 16'd0;
    end else if (state_q == SAMPLE && cand > limit_reg && reject_cnt != 16'hFFFF) begin
      reject_cnt <= reject_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// tb/tb_lfsr_rand_gen.sv - scoreboard bench for lfsr_rand_gen (MAX_TRIES 8 and 1 instances)
module tb_lfsr_rand_gen;

  logic       clk = 1'b0;
  logic       reset, ce, seed_load, req;
  logic [7:0] seed, limit;
  logic [7:0] lfsr_a, rnd_a, lfsr_b, rnd_b;
  logic       wrap_a, busy_a, rv_a, wrap_b, busy_b, rv_b;
`ifdef LFSR_REJECT_CNT_EN
  logic [15:0] rc_a, rc_b;
`endif

  always #5 clk = ~clk;

  lfsr_rand_gen #(.WIDTH(8), .MAX_TRIES(8)) dut (
    .clk(clk), .reset(reset), .ce(ce), .seed_load(seed_load), .seed(seed),
    .req(req), .limit(limit), .lfsr(lfsr_a), .wrap(wrap_a), .busy(busy_a),
    .rnd_valid(rv_a), .rnd(rnd_a)
`ifdef LFSR_REJECT_CNT_EN
    , .reject_cnt(rc_a)
`endif
  );

  lfsr_rand_gen #(.WIDTH(8), .MAX_TRIES(1)) dut1 (
    .clk(clk), .reset(reset), .ce(ce), .seed_load(seed_load), .seed(seed),
    .req(req), .limit(limit), .lfsr(lfsr_b), .wrap(wrap_b), .busy(busy_b),
    .rnd_valid(rv_b), .rnd(rnd_b)
`ifdef LFSR_REJECT_CNT_EN
    , .reject_cnt(rc_b)
`endif
  );

  typedef struct {
    logic [7:0] rnd;
    int         due;
  } exp_t;

  exp_t       q_a[$], q_b[$];
  exp_t       e_a, e_b;
  int         n_cmp = 0, n_bad = 0;
  int         cyc = 0;
  logic [7:0] m_a, m_b, sd;
  int         rej_a, rej_b;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] nx(input logic [7:0] x);
    return {x[6:0], ~(x[7] ^ x[5] ^ x[4] ^ x[3])};
  endfunction

  task automatic model_sample(input logic [7:0] s0, input logic [7:0] lim, input int maxt,
                              output logic [7:0] r, output int k, output logic [7:0] s_end,
                              output int rej);
    logic [7:0] m, s, cand;
    m = 8'd0;
    while (m < lim) m = {m[6:0], 1'b1};
    s = s0; r = 8'd0; k = 0; rej = 0;
    for (int t = 0; t < maxt; t++) begin
      cand = s & m;
      s = nx(s);
      k = t + 1;
      if (cand <= lim) begin
        r = cand;
        break;
      end
      rej++;
      if (t == maxt - 1) r = cand - lim - 8'd1;
    end
    s_end = s;
  endtask

  // Scoreboard: pop expected result whenever a DUT produces one.
  always @(negedge clk) begin
    if (rv_a === 1'b1) begin
      if (q_a.size() == 0) check("a_spurious_valid", 1, 0);
      else begin
        e_a = q_a.pop_front();
        check("a_rnd", rnd_a, e_a.rnd);
        check("a_latency", cyc, e_a.due);
        check("a_busy_drop", busy_a, 0);
      end
    end
    if (rv_b === 1'b1) begin
      if (q_b.size() == 0) check("b_spurious_valid", 1, 0);
      else begin
        e_b = q_b.pop_front();
        check("b_rnd", rnd_b, e_b.rnd);
        check("b_latency", cyc, e_b.due);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; ce = 1'b0; seed_load = 1'b0; req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_a = 8'd0; m_b = 8'd0; sd = 8'd0; rej_a = 0; rej_b = 0;
    q_a.delete(); q_b.delete();
  endtask

  task automatic load(input logic [7:0] s);
    seed = s; seed_load = 1'b1; ce = 1'b0;
    @(negedge clk);
    seed_load = 1'b0;
    sd = (s == 8'hFF) ? 8'd0 : s;
    m_a = sd; m_b = sd;
    check("load_lfsr", lfsr_a, sd);
    check("load_no_wrap", wrap_a, 0);
  endtask

  task automatic step(input int n, output int wraps, output int errs);
    wraps = 0; errs = 0;
    ce = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      m_a = nx(m_a); m_b = nx(m_b);
      if (wrap_a) wraps++;
      if (lfsr_a !== m_a || lfsr_a == 8'hFF) errs++;
    end
    ce = 1'b0;
  endtask

  task automatic do_req(input logic [7:0] lim, input int hold);
    logic [7:0] r, s;
    int k, rej;
    ce = 1'b0; seed_load = 1'b0; req = 1'b1; limit = lim;
    model_sample(m_a, lim, 8, r, k, s, rej);
    q_a.push_back('{rnd: r, due: cyc + 1 + k}); m_a = s; rej_a += rej;
    model_sample(m_b, lim, 1, r, k, s, rej);
    q_b.push_back('{rnd: r, due: cyc + 1 + k}); m_b = s; rej_b += rej;
    @(negedge clk);
    check("busy_after_req", busy_a, 1);
    for (int i = 1; i < hold; i++) @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    check("req_timeout", q_a.size() + q_b.size(), 0);
    q_a.delete(); q_b.delete();
    check("a_lfsr_after_req", lfsr_a, m_a);
    check("b_lfsr_after_req", lfsr_b, m_b);
  endtask

  initial begin
    logic [7:0] seqv [6];
    int wraps, errs, wtot, etot, ffs;
    seqv = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};
    seed = 8'd0; limit = 8'd0;
    do_reset();
    do_reset();
    check("rst_lfsr", lfsr_a, 0);
    check("rst_wrap", wrap_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_valid", rv_a, 0);
    check("rst_rnd", rnd_a, 0);

    // Free-running sequence and full period from reset.
    check("seq", lfsr_a, seqv[0]);
    wtot = 0; etot = 0; ffs = 0;
    for (int i = 1; i <= 255; i++) begin
      step(1, wraps, errs);
      wtot += wraps; etot += errs;
      if (lfsr_a == 8'hFF) ffs++;
      if (i < 6) check("seq", lfsr_a, seqv[i]);
    end
    check("period_return", lfsr_a, 0);
    check("wrap_once", wtot, 1);
    check("no_lockup", ffs, 0);
    check("track_errs", etot, 0);

    // Seed loading, lockup seed, wrap after a full period from a seed.
    load(8'hFF);
    load(8'h5A);
    step(254, wraps, errs);
    check("seed_wrap_early", wraps, 0);
    check("seed_track", errs, 0);
    step(1, wraps, errs);
    check("seed_wrap", wraps, 1);
    check("seed_return", lfsr_a, 8'h5A);

    // Rejection sampling and fallback.
    load(8'h0F);
    do_req(8'd9, 1);
    do_req(8'd0, 2);
    do_req(8'hFF, 1);
    for (int i = 0; i < 6; i++) begin
      step($urandom_range(1, 20), wraps, errs);
      check("rand_track", errs, 0);
      do_req(8'($urandom_range(0, 255)), 1);
    end
`ifdef LFSR_REJECT_CNT_EN
    check("a_reject_cnt", rc_a, rej_a);
    check("b_reject_cnt", rc_b, rej_b);
`endif

    // Reset in the middle of SAMPLE: no result, outputs back to reset values.
    load(8'h0F);
    req = 1'b1; limit = 8'd9;
    @(negedge clk);
    req = 1'b0;
    check("mid_busy", busy_a, 1);
    do_reset();
    check("mid_rst_lfsr", lfsr_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_valid", rv_a, 0);
    check("mid_rst_rnd", rnd_a, 0);
    check("mid_rst_b_busy", busy_b, 0);
    check("mid_rst_b_rnd", rnd_b, 0);
`ifdef LFSR_REJECT_CNT_EN
    check("mid_rst_rc", rc_a, 0);
`endif
    repeat (12) @(negedge clk);
    check("idle_after_rst", busy_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
